rob: RTL and testbench

- 16-entry, 4-wide in-order-retire reorder buffer for the out-of-order core, sitting between rename/dispatch and the physical-register free list.
- Rename allocates up to 4 entries per cycle; each entry records the previous physical register mapped to the destination ("old_p").
- Six execution/completion ports mark entries done by ROB index.
- Up to 4 consecutive done entries retire from the head each cycle, and their old_p values are returned to the free list.

---
 rtl/rob_pkg.sv | 13 +
 rtl/rob_retire_sel.sv | 28 ++
 rtl/rob.sv | 139 +++++++++++++
 tb/tb_rob.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - shared constants and types for the reorder buffer
package rob_pkg;
    localparam int ROB_DEPTH  = 16;
    localparam int ROB_IDX_W  = 4;
    localparam int PREG_W     = 6;
    localparam int BUNDLE_W   = 57;
    localparam int ISSUE_W    = 4;
    localparam int CMPL_PORTS = 6;
    localparam int OCC_W      = ROB_IDX_W + 1;

    typedef logic [ROB_IDX_W-1:0] rob_idx_t;
    typedef logic [PREG_W-1:0]    preg_t;
endpackage

// File: rtl/rob_retire_sel.sv
// rtl/rob_retire_sel.sv - counts consecutive done entries at the head (max 4)
module rob_retire_sel
    import rob_pkg::*;
(
    input  rob_idx_t                  i_head,
    input  logic [OCC_W-1:0]          i_occupancy,
    input  logic [ROB_DEPTH-1:0]      i_done,
    output logic [2:0]                o_count,
    output rob_idx_t [ISSUE_W-1:0]    o_idx
);

    // Walk the four slots from head; the first not-done or unoccupied slot stops the run.
    always_comb begin
        logic run;
        run     = 1'b1;
        o_count = '0;
        o_idx   = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            o_idx[k] = i_head + rob_idx_t'(k);
            if (run && (OCC_W'(k) < i_occupancy) && i_done[o_idx[k]]) begin
                o_count = o_count + 3'd1;
            end else begin
                run = 1'b0;
            end
        end
    end

endmodule

// File: rtl/rob.sv
// rtl/rob.sv - 16-entry, 4-wide in-order-retire reorder buffer
module rob
    import rob_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [2:0]            i_ins_count,
    input  logic [BUNDLE_W-1:0]   i_ins_bundle0,
    input  logic [BUNDLE_W-1:0]   i_ins_bundle1,
    input  logic [BUNDLE_W-1:0]   i_ins_bundle2,
    input  logic [BUNDLE_W-1:0]   i_ins_bundle3,
    input  logic [PREG_W-1:0]     i_ins_old_p0,
    input  logic [PREG_W-1:0]     i_ins_old_p1,
    input  logic [PREG_W-1:0]     i_ins_old_p2,
    input  logic [PREG_W-1:0]     i_ins_old_p3,
    input  logic [CMPL_PORTS-1:0] i_cmpl_en,
    input  logic [ROB_IDX_W-1:0]  i_cmpl0,
    input  logic [ROB_IDX_W-1:0]  i_cmpl1,
    input  logic [ROB_IDX_W-1:0]  i_cmpl2,
    input  logic [ROB_IDX_W-1:0]  i_cmpl3,
    input  logic [ROB_IDX_W-1:0]  i_cmpl4,
    input  logic [ROB_IDX_W-1:0]  i_cmpl5,
    output logic [ROB_IDX_W-1:0]  o_tail,
    output logic [OCC_W-1:0]      o_free_count,
    output logic [2:0]            o_retire_count,
    output logic [PREG_W-1:0]     o_retire_old_p0,
    output logic [PREG_W-1:0]     o_retire_old_p1,
    output logic [PREG_W-1:0]     o_retire_old_p2,
    output logic [PREG_W-1:0]     o_retire_old_p3
);

    rob_idx_t               head_q, head_d;
    rob_idx_t               tail_q, tail_d;
    logic [OCC_W-1:0]       occ_q, occ_d;
    logic [ROB_DEPTH-1:0]   done_q, done_d;
    preg_t                  old_p_q [ROB_DEPTH];
    preg_t                  old_p_d [ROB_DEPTH];
    logic [2:0]             ret_cnt_q, ret_cnt_d;
    preg_t                  ret_p_q [ISSUE_W];
    preg_t                  ret_p_d [ISSUE_W];

    preg_t                  ins_old_p [ISSUE_W];
    rob_idx_t               cmpl_idx [CMPL_PORTS];
    logic [2:0]             ret_n;
    rob_idx_t [ISSUE_W-1:0] ret_idx;
    logic [2:0]             alloc_n;
    logic                   unused_bundle;

    // Bundles are carried on the interface but not stored yet.
    assign unused_bundle = ^{i_ins_bundle0, i_ins_bundle1, i_ins_bundle2, i_ins_bundle3};

    assign ins_old_p[0] = i_ins_old_p0;
    assign ins_old_p[1] = i_ins_old_p1;
    assign ins_old_p[2] = i_ins_old_p2;
    assign ins_old_p[3] = i_ins_old_p3;
    assign cmpl_idx[0]  = i_cmpl0;
    assign cmpl_idx[1]  = i_cmpl1;
    assign cmpl_idx[2]  = i_cmpl2;
    assign cmpl_idx[3]  = i_cmpl3;
    assign cmpl_idx[4]  = i_cmpl4;
    assign cmpl_idx[5]  = i_cmpl5;

    assign o_tail          = tail_q;
    assign o_free_count    = OCC_W'(ROB_DEPTH) - occ_q;
    assign o_retire_count  = ret_cnt_q;
    assign o_retire_old_p0 = ret_p_q[0];
    assign o_retire_old_p1 = ret_p_q[1];
    assign o_retire_old_p2 = ret_p_q[2];
    assign o_retire_old_p3 = ret_p_q[3];

    rob_retire_sel u_retire_sel (
        .i_head      (head_q),
        .i_occupancy (occ_q),
        .i_done      (done_q),
        .o_count     (ret_n),
        .o_idx       (ret_idx)
    );

    // All-or-nothing allocation against pre-edge free space.
    always_comb begin
        alloc_n = '0;
        if ((i_ins_count <= 3'd4) && ({2'b00, i_ins_count} <= o_free_count)) begin
            alloc_n = i_ins_count;
        end
    end

    // Next state: retire clears, completion sets, allocation clears last so it wins.
    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        occ_d     = occ_q;
        done_d    = done_q;
        old_p_d   = old_p_q;
        ret_cnt_d = ret_n;
        for (int k = 0; k < ISSUE_W; k++) begin
            ret_p_d[k] = '0;
            if (3'(k) < ret_n) begin
                ret_p_d[k]          = old_p_q[ret_idx[k]];
                done_d[ret_idx[k]]  = 1'b0;
            end
        end
        for (int j = 0; j < CMPL_PORTS; j++) begin
            if (i_cmpl_en[j]) begin
                done_d[cmpl_idx[j]] = 1'b1;
            end
        end
        for (int k = 0; k < ISSUE_W; k++) begin
            if (3'(k) < alloc_n) begin
                old_p_d[tail_q + rob_idx_t'(k)] = ins_old_p[k];
                done_d[tail_q + rob_idx_t'(k)]  = 1'b0;
            end
        end
        head_d = head_q + rob_idx_t'(ret_n);
        tail_d = tail_q + rob_idx_t'(alloc_n);
        occ_d  = occ_q + OCC_W'(alloc_n) - OCC_W'(ret_n);
    end

    // State registers; reset empties the buffer and clears the retire outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            head_q    <= '0;
            tail_q    <= '0;
            occ_q     <= '0;
            done_q    <= '0;
            ret_cnt_q <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) old_p_q[i] <= '0;
            for (int k = 0; k < ISSUE_W; k++)   ret_p_q[k] <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            occ_q     <= occ_d;
            done_q    <= done_d;
            ret_cnt_q <= ret_cnt_d;
            old_p_q   <= old_p_d;
            ret_p_q   <= ret_p_d;
        end
    end

endmodule

// File: tb/tb_rob.sv
// tb/tb_rob.sv - scoreboard bench for the reorder buffer
module tb_rob;
    logic        clk;
    logic        rst_n;
    logic [2:0]  ins_count;
    logic [56:0] bundle [4];
    logic [5:0]  old_p [4];
    logic [5:0]  cmpl_en;
    logic [3:0]  cmpl [6];
    logic [3:0]  tail;
    logic [4:0]  free_count;
    logic [2:0]  ret_count;
    logic [5:0]  ret_p0, ret_p1, ret_p2, ret_p3;

    int checks = 0;
    int errors = 0;
    logic [26:0] exp_q [$];

    rob dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_ins_count    (ins_count),
        .i_ins_bundle0  (bundle[0]),
        .i_ins_bundle1  (bundle[1]),
        .i_ins_bundle2  (bundle[2]),
        .i_ins_bundle3  (bundle[3]),
        .i_ins_old_p0   (old_p[0]),
        .i_ins_old_p1   (old_p[1]),
        .i_ins_old_p2   (old_p[2]),
        .i_ins_old_p3   (old_p[3]),
        .i_cmpl_en      (cmpl_en),
        .i_cmpl0        (cmpl[0]),
        .i_cmpl1        (cmpl[1]),
        .i_cmpl2        (cmpl[2]),
        .i_cmpl3        (cmpl[3]),
        .i_cmpl4        (cmpl[4]),
        .i_cmpl5        (cmpl[5]),
        .o_tail         (tail),
        .o_free_count   (free_count),
        .o_retire_count (ret_count),
        .o_retire_old_p0(ret_p0),
        .o_retire_old_p1(ret_p1),
        .o_retire_old_p2(ret_p2),
        .o_retire_old_p3(ret_p3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [26:0] mk(int c, int p0, int p1, int p2, int p3);
        return {3'(c), 6'(p3), 6'(p2), 6'(p1), 6'(p0)};
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ins_count = 3'd0;
        cmpl_en   = 6'd0;
        for (int k = 0; k < 4; k++) old_p[k] = 6'd0;
        for (int j = 0; j < 6; j++) cmpl[j] = 4'd0;
    endtask

    task automatic alloc(int n, int p0, int p1, int p2, int p3);
        ins_count = 3'(n);
        old_p[0] = 6'(p0); old_p[1] = 6'(p1); old_p[2] = 6'(p2); old_p[3] = 6'(p3);
    endtask

    task automatic complete(int j, int idx);
        cmpl_en[j] = 1'b1;
        cmpl[j]    = 4'(idx);
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        #1;
    endtask

    // Monitor: each nonzero retire report pops and checks the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && ret_count != 3'd0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_retire: got count %0d expected none", ret_count);
            end else begin
                logic [26:0] e;
                e = exp_q.pop_front();
                chk("retire_bundle", int'({ret_count, ret_p3, ret_p2, ret_p1, ret_p0}), int'(e));
            end
        end
    end

    initial begin
        for (int k = 0; k < 4; k++) bundle[k] = 57'(k * 3 + 1);
        rst_n = 1'b0;
        idle();
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("reset_free", free_count, 16);
        chk("reset_retire_count", ret_count, 0);
        chk("reset_tail", tail, 0);

        // Allocate one, complete it, retire it.
        alloc(1, 5, 0, 0, 0); step();
        chk("alloc1_free", free_count, 15);
        chk("alloc1_tail", tail, 1);
        idle(); complete(0, 0); step();
        idle(); exp_q.push_back(mk(1, 5, 0, 0, 0)); step();
        chk("alloc1_free_after", free_count, 16);
        step();

        // In-order retire: out-of-order completion holds until the head completes.
        do_reset();
        alloc(3, 1, 2, 3, 0); step();
        idle(); complete(0, 1); complete(1, 2); step();
        idle(); step(); step(); step();
        chk("inorder_hold_free", free_count, 13);
        complete(0, 0); step();
        idle(); exp_q.push_back(mk(3, 1, 2, 3, 0)); step();
        chk("inorder_free_after", free_count, 16);
        step();

        // Out-of-range count is dropped.
        alloc(5, 1, 1, 1, 1); step();
        chk("count5_tail", tail, 3);
        chk("count5_free", free_count, 16);

        // Fill, overflow, drain, wrap.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            alloc(4, 10 + 4 * c, 11 + 4 * c, 12 + 4 * c, 13 + 4 * c); step();
        end
        chk("full_free", free_count, 0);
        chk("full_tail", tail, 0);
        alloc(1, 63, 0, 0, 0); step();
        chk("overflow_tail", tail, 0);
        chk("overflow_free", free_count, 0);
        idle();
        for (int c = 0; c < 4; c++)
            exp_q.push_back(mk(4, 10 + 4 * c, 11 + 4 * c, 12 + 4 * c, 13 + 4 * c));
        for (int j = 0; j < 6; j++) complete(j, j);
        step();
        idle(); for (int j = 0; j < 6; j++) complete(j, 6 + j);
        step();
        chk("drain1_free", free_count, 4);
        idle(); for (int j = 0; j < 4; j++) complete(j, 12 + j);
        step();
        idle(); step(); step(); step(); step();
        chk("drain_free", free_count, 16);
        chk("wrap_tail", tail, 0);
        alloc(2, 40, 41, 0, 0); step();
        chk("wrap_alloc_tail", tail, 2);
        idle(); complete(0, 0); complete(1, 1); step();
        idle(); exp_q.push_back(mk(2, 40, 41, 0, 0)); step();
        step();

        // Simultaneous retire, allocate and complete.
        do_reset();
        alloc(4, 1, 2, 3, 4); step();
        idle(); complete(0, 0); complete(1, 1); step();
        idle(); alloc(2, 5, 6, 0, 0); complete(0, 2);
        exp_q.push_back(mk(2, 1, 2, 0, 0)); step();
        chk("simul_free", free_count, 12);
        chk("simul_tail", tail, 6);
        idle(); alloc(1, 7, 0, 0, 0); complete(0, 6);
        exp_q.push_back(mk(1, 3, 0, 0, 0)); step();
        chk("alloc_wins_free", free_count, 12);
        idle(); complete(0, 3); complete(1, 4); complete(2, 5); step();
        idle(); exp_q.push_back(mk(3, 4, 5, 6, 0)); step();
        chk("alloc_wins_hold_free", free_count, 15);
        step(); step();
        complete(0, 6); step();
        idle(); exp_q.push_back(mk(1, 7, 0, 0, 0)); step();
        chk("simul_final_free", free_count, 16);
        step();

        // Reset mid-operation.
        alloc(4, 8, 9, 10, 11); step();
        idle(); complete(0, 7); step();
        idle(); exp_q.push_back(mk(1, 8, 0, 0, 0)); step();
        chk("pending_free", free_count, 13);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_free", free_count, 16);
        chk("midrst_retire_count", ret_count, 0);
        chk("midrst_tail", tail, 0);
        chk("midrst_retire_p0", ret_p0, 0);
        step(); step();
        rst_n = 1'b1;
        complete(0, 0); complete(1, 1); step();
        idle(); step(); step();
        chk("postrst_free", free_count, 16);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
